fpu_result_stage16: RTL and testbench

- Retire stage directly downstream of the 16-bit FP add/sub unit.
- Accepts each result word and its condition codes {Z,C,N,V} through a valid/ready handshake and buffers them in a small FIFO.
- Canonicalizes NaNs and presents results to the register-file/writeback port.
- On every retire, updates an architectural condition-code register, sticky exception flags and a retire counter.

---
 rtl/fpu_result_stage16.sv | 118 +++++++++++
 tb/tb_fpu_result_stage16.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_result_stage16.sv
// Retire stage behind the fp16 add/sub unit: a small FIFO of result words
// and condition codes {Z,C,N,V}, NaN canonicalization at the head, and
// architectural cc register, sticky exception flags and a retire counter
// that update whenever the writeback port takes the head entry.
module fpu_result_stage16 #(
    parameter int DEPTH     = 2,   // power of two, >= 2
    parameter int CANON_NAN = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_result,
    input  logic [3:0]       in_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic [3:0]       out_cc,
    output logic [3:0]       cc_reg,
    output logic [2:0]       sticky_flags,
    input  logic             flags_clear,
    output logic [CNT_W-1:0] retire_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL_COUNT = OCC_W'(DEPTH);
    localparam logic [15:0] CANON_QNAN = 16'h7E00;

    // fp16 classification on the exponent/fraction fields
    function automatic logic isNan(input logic [4:0] expField, input logic [9:0] fracField);
        return (expField == 5'h1F) && (fracField != 10'd0);
    endfunction

    function automatic logic isInf(input logic [4:0] expField, input logic [9:0] fracField);
        return (expField == 5'h1F) && (fracField == 10'd0);
    endfunction

    // Replace any NaN by the single quiet-NaN pattern when enabled
    function automatic logic [15:0] canonResult(input logic [15:0] word);
        if ((CANON_NAN != 0) && isNan(word[14:10], word[9:0]))
            return CANON_QNAN;
        return word;
    endfunction

    logic [15:0]      resultMem [DEPTH];
    logic [3:0]       ccMem     [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [OCC_W-1:0] entryCount;
    logic             push;
    logic             pop;
    logic [15:0]      headResult;
    logic [3:0]       headCc;
    logic [2:0]       stickyNew;
    logic [2:0]       stickyBase;

    // Handshake depends only on registered occupancy, never on out_ready
    assign in_ready   = (entryCount != FULL_COUNT);
    assign out_valid  = (entryCount != '0);
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;

    assign headResult = resultMem[rdPtr];
    assign headCc     = ccMem[rdPtr];
    assign out_result = canonResult(headResult);
    assign out_cc     = headCc;

    // Flag contributions come from the stored word, before canonicalization;
    // a retire in the same cycle as a clear still sets its bits
    assign stickyNew  = pop ? {isNan(headResult[14:10], headResult[9:0]),
                               isInf(headResult[14:10], headResult[9:0]),
                               headCc[0]} : 3'b000;
    assign stickyBase = flags_clear ? 3'b000 : sticky_flags;

    // FIFO storage is data only and is left unreset
    always_ff @(posedge clock) begin
        if (push) begin
            resultMem[wrPtr] <= in_result;
            ccMem[wrPtr]     <= in_cc;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^PTR_W
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            entryCount <= '0;
        end else begin
            if (push)
                wrPtr <= wrPtr + PTR_W'(1);
            if (pop)
                rdPtr <= rdPtr + PTR_W'(1);
            if (push && !pop)
                entryCount <= entryCount + OCC_W'(1);
            else if (pop && !push)
                entryCount <= entryCount - OCC_W'(1);
        end
    end

    // Architectural state updated on each retire
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            cc_reg       <= 4'b0000;
            sticky_flags <= 3'b000;
            retire_count <= '0;
        end else begin
            sticky_flags <= stickyBase | stickyNew;
            if (pop) begin
                cc_reg       <= headCc;
                retire_count <= retire_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fpu_result_stage16.sv
// Scoreboard bench for fpu_result_stage16: the stimulus side records every
// accepted word in a queue, a monitor on the falling edge compares the head
// and the architectural state against a reference model of the retire rules.
module tb_fpu_result_stage16;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic             clock = 1'b0;
    logic             reset_L = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_result = 16'h0000;
    logic [3:0]       in_cc = 4'h0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15:0]      out_result;
    logic [3:0]       out_cc;
    logic [3:0]       cc_reg;
    logic [2:0]       sticky_flags;
    logic             flags_clear = 1'b0;
    logic [CNT_W-1:0] retire_count;

    int nCompared = 0;
    int nMismatched = 0;

    typedef struct {
        logic [15:0] raw;
        logic [3:0]  cc;
    } entry_t;

    entry_t      sbq[$];
    logic [3:0]  expCc = 4'h0;
    logic [2:0]  expSticky = 3'b000;
    logic [CNT_W-1:0] expCount = '0;

    fpu_result_stage16 #(.DEPTH(DEPTH), .CANON_NAN(1), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_L(reset_L),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_cc(in_cc),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_cc(out_cc),
        .cc_reg(cc_reg), .sticky_flags(sticky_flags), .flags_clear(flags_clear),
        .retire_count(retire_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic refIsNan(input logic [15:0] w);
        logic [4:0] e;
        logic [9:0] f;
        e = w[14:10];
        f = w[9:0];
        return (e == 5'd31) && (f != 10'd0);
    endfunction

    function automatic logic refIsInf(input logic [15:0] w);
        logic [4:0] e;
        logic [9:0] f;
        e = w[14:10];
        f = w[9:0];
        return (e == 5'd31) && (f == 10'd0);
    endfunction

    // Monitor: outputs are stable mid-cycle; decide what the next edge will do
    always @(negedge clock) begin
        if (!reset_L) begin
            sbq.delete();
            expCc = 4'h0;
            expSticky = 3'b000;
            expCount = '0;
        end else begin
            bit popM;
            bit pushM;
            check("cc_reg", 32'(cc_reg), 32'(expCc));
            check("sticky_flags", 32'(sticky_flags), 32'(expSticky));
            check("retire_count", 32'(retire_count), 32'(expCount));
            check("out_valid", 32'(out_valid), 32'(sbq.size() != 0));
            check("in_ready", 32'(in_ready), 32'(sbq.size() != DEPTH));
            popM  = (sbq.size() != 0) && out_ready;
            pushM = in_valid && (sbq.size() != DEPTH);
            if (flags_clear)
                expSticky = 3'b000;
            if (popM) begin
                entry_t e;
                logic [15:0] want;
                e = sbq.pop_front();
                want = refIsNan(e.raw) ? 16'h7E00 : e.raw;
                check("out_result", 32'(out_result), 32'(want));
                check("out_cc", 32'(out_cc), 32'(e.cc));
                expCc = e.cc;
                expCount = expCount + 1'b1;
                expSticky = expSticky | {refIsNan(e.raw), refIsInf(e.raw), e.cc[0]};
            end
            if (pushM) begin
                entry_t n;
                n.raw = in_result;
                n.cc = in_cc;
                sbq.push_back(n);
            end
        end
    end

    // Protocol properties
    always @(negedge clock) begin
        if (reset_L) begin
            assert (dut.entryCount <= DEPTH);
            assert (!(in_valid && in_ready && dut.entryCount == DEPTH));
            assert (!(out_valid && out_ready && dut.entryCount == 0));
        end
    end

    task automatic cycle(input logic iv, input logic [15:0] res, input logic [3:0] cc,
                         input logic ordy, input logic fclr);
        @(posedge clock);
        #1;
        in_valid = iv;
        in_result = res;
        in_cc = cc;
        out_ready = ordy;
        flags_clear = fclr;
    endtask

    function automatic logic [15:0] randWord();
        case ($urandom_range(0, 5))
            0: return {$urandom_range(0, 1) != 0 ? 1'b1 : 1'b0, 5'h1F, 10'(32'($urandom_range(1, 1023)))};
            1: return ($urandom_range(0, 1) != 0) ? 16'h7C00 : 16'hFC00;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        #1 reset_L = 1'b1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_cc_reg", 32'(cc_reg), 0);
        check("rst_sticky", 32'(sticky_flags), 0);
        check("rst_retire_count", 32'(retire_count), 0);

        // Single retire
        cycle(1, 16'h3C00, 4'b0000, 1, 0);
        cycle(0, 16'h0000, 4'b0000, 1, 0);
        check("single_out_valid", 32'(out_valid), 1);
        check("single_out_result", 32'(out_result), 32'h3C00);
        cycle(0, 16'h0000, 4'b0000, 0, 0);
        check("single_cc_reg", 32'(cc_reg), 0);
        check("single_retire_count", 32'(retire_count), 1);
        check("single_out_valid_after", 32'(out_valid), 0);

        // Backpressure
        cycle(1, 16'h4000, 4'b0000, 0, 0);
        cycle(1, 16'h4200, 4'b0000, 0, 0);
        cycle(1, 16'h4400, 4'b0000, 0, 0);
        check("bp_in_ready_full", 32'(in_ready), 0);
        cycle(0, 16'h0000, 4'b0000, 0, 0);
        check("bp_head", 32'(out_result), 32'h4000);
        cycle(0, 16'h0000, 4'b0000, 1, 0);
        cycle(0, 16'h0000, 4'b0000, 1, 0);
        check("bp_in_ready_back", 32'(in_ready), 1);
        check("bp_second", 32'(out_result), 32'h4200);
        cycle(0, 16'h0000, 4'b0000, 0, 0);
        check("bp_retire_count", 32'(retire_count), 3);

        // NaN then -Inf
        cycle(1, 16'h7C01, 4'b0000, 0, 0);
        cycle(0, 16'h0000, 4'b0000, 1, 0);
        check("nan_canon", 32'(out_result), 32'h7E00);
        cycle(0, 16'h0000, 4'b0000, 0, 0);
        check("nan_sticky", 32'(sticky_flags), 32'b100);
        cycle(1, 16'hFC00, 4'b0000, 1, 0);
        cycle(0, 16'h0000, 4'b0000, 1, 0);
        cycle(0, 16'h0000, 4'b0000, 0, 0);
        check("inf_sticky", 32'(sticky_flags), 32'b110);

        // Overflow retire racing a clear
        cycle(1, 16'hC000, 4'b0011, 0, 0);
        cycle(0, 16'h0000, 4'b0000, 1, 1);
        cycle(0, 16'h0000, 4'b0000, 0, 0);
        check("race_sticky", 32'(sticky_flags), 32'b001);
        check("race_cc_reg", 32'(cc_reg), 32'b0011);

        // Reset mid-operation with both entries full
        cycle(1, 16'h1111, 4'b1010, 0, 0);
        cycle(1, 16'h2222, 4'b0101, 0, 0);
        cycle(0, 16'h0000, 4'b0000, 0, 0);
        check("mid_full", 32'(in_ready), 0);
        #2 reset_L = 1'b0;
        #1;
        check("mid_out_valid", 32'(out_valid), 0);
        check("mid_in_ready", 32'(in_ready), 1);
        check("mid_cc_reg", 32'(cc_reg), 0);
        check("mid_sticky", 32'(sticky_flags), 0);
        check("mid_retire_count", 32'(retire_count), 0);
        @(posedge clock);
        #1 reset_L = 1'b1;
        out_ready = 1'b1;
        repeat (3) cycle(0, 16'h0000, 4'b0000, 1, 0);
        check("mid_no_stale", 32'(out_valid), 0);

        // Streaming at one word per cycle
        for (int i = 0; i < 100; i++) begin
            cycle(1, 16'(i + 16'h0100), 4'(i), 1, 0);
            if (i >= 1) begin
                check("stream_out_valid", 32'(out_valid), 1);
                check("stream_in_ready", 32'(in_ready), 1);
            end
        end
        cycle(0, 16'h0000, 4'b0000, 1, 0);
        cycle(0, 16'h0000, 4'b0000, 1, 0);
        check("stream_retire_count", 32'(retire_count), 100);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, randWord(), 4'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end

        // Drain, bounded
        for (int i = 0; i < 20 && sbq.size() != 0; i++)
            cycle(0, 16'h0000, 4'b0000, 1, 0);
        cycle(0, 16'h0000, 4'b0000, 0, 0);
        check("drain_queue_empty", 32'(sbq.size()), 0);
        check("drain_out_valid", 32'(out_valid), 0);

        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
